// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: per-channel synchroniser, debounce and
// level/edge pending logic, fixed-priority arbitration and a claim/complete FSM.

module ext_irq_chan #(
    parameter int DEB_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             irq_in,
    input  logic             en,
    input  logic             edge_mode,
    input  logic [DEB_W-1:0] cfg_deb,
    input  logic             clr,
    input  logic             in_svc,
    output logic             pend,
    output logic             pend_nxt
);
    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             rise;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == cfg_deb) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign rise = stable_d & ~stable_q;

    // Level mode tracks the debounced value being written this edge, so both
    // modes raise pend on the same edge as stable.
    always_comb begin
        pend_d = pend_q;
        if (!en) begin
            pend_d = 1'b0;
        end else if (edge_mode) begin
            if (rise) begin
                pend_d = 1'b1;
            end else if (clr) begin
                pend_d = 1'b0;
            end
        end else begin
            pend_d = stable_d & ~in_svc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            sync1_q  <= irq_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
        end
    end

    assign pend     = pend_q;
    assign pend_nxt = pend_d;
endmodule

module ext_irq_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int IDW     = 3,
    parameter int DEB_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] cfg_en,
    input  logic [NUM_IRQ-1:0] cfg_edge,
    input  logic [DEB_W-1:0]   cfg_deb,
    output logic               irq_req,
    output logic [IDW-1:0]     irq_id,
    input  logic               irq_claim,
    input  logic               irq_complete,
    output logic               busy,
    output logic [NUM_IRQ-1:0] pend
);
    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t             state_q, state_d;
    logic               irq_req_q, irq_req_d;
    logic [IDW-1:0]     irq_id_q, irq_id_d;
    logic               busy_q, busy_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic               claim_ok;
    logic               svc_nxt;
    logic [IDW-1:0]     low_id;

    assign claim_ok = (state_q == REQ) && irq_claim;
    // Service status for the coming cycle; level channels use it so pend reads
    // 0 from the first SVC cycle onward.
    assign svc_nxt  = claim_ok || ((state_q == SVC) && !irq_complete);

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
        ext_irq_chan #(.DEB_W(DEB_W)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .irq_in    (irq_in[g]),
            .en        (cfg_en[g]),
            .edge_mode (cfg_edge[g]),
            .cfg_deb   (cfg_deb),
            .clr       (claim_ok && (irq_id_q == IDW'(g))),
            .in_svc    (svc_nxt && (irq_id_q == IDW'(g))),
            .pend      (pend_q[g]),
            .pend_nxt  (pend_d[g])
        );
    end

    always_comb begin
        low_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i]) low_id = IDW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        irq_req_d = irq_req_q;
        irq_id_d  = irq_id_q;
        busy_d    = busy_q;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    irq_id_d  = low_id;
                    irq_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (irq_claim) begin
                    irq_req_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SVC;
                end else if (!pend_d[irq_id_q]) begin
                    irq_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            SVC: begin
                if (irq_complete) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                irq_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
            busy_q    <= busy_d;
        end
    end

    assign irq_req = irq_req_q;
    assign irq_id  = irq_id_q;
    assign busy    = busy_q;
    assign pend    = pend_q;
endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl: a cycle model built from the behavioural
// rules is compared every cycle, plus hand-computed literal checkpoints.

module tb_ext_irq_ctrl;
    localparam int N   = 8;
    localparam int IDW = 3;
    localparam int DW  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   irq_in, cfg_en, cfg_edge;
    logic [DW-1:0]  cfg_deb;
    logic           irq_req, irq_claim, irq_complete, busy;
    logic [IDW-1:0] irq_id;
    logic [N-1:0]   pend;

    int n_tests = 0;
    int n_fail  = 0;

    ext_irq_ctrl #(.NUM_IRQ(N), .IDW(IDW), .DEB_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .cfg_en(cfg_en),
        .cfg_edge(cfg_edge), .cfg_deb(cfg_deb), .irq_req(irq_req),
        .irq_id(irq_id), .irq_claim(irq_claim), .irq_complete(irq_complete),
        .busy(busy), .pend(pend)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Model: sync delay line, mismatch run length, pending bits, service phase
    // (0 = nothing presented, 1 = presented, 2 = in service).
    bit [N-1:0] m_s1, m_s2, m_stb, m_pnd;
    int         m_run [N];
    int         m_ph;
    int         m_id;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stb = '0; m_pnd = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_ph = 0; m_id = 0;
    endtask

    task automatic model_update();
        bit [N-1:0] np;
        bit         will_svc;
        bit         ns, rise;
        if (!rst_n) begin
            model_reset();
            return;
        end
        will_svc = (m_ph == 2 && !irq_complete) || (m_ph == 1 && irq_claim);
        for (int i = 0; i < N; i++) begin
            ns = m_stb[i];
            if (m_s2[i] != m_stb[i]) begin
                if (m_run[i] == int'(cfg_deb)) begin
                    ns = m_s2[i];
                    m_run[i] = 0;
                end else m_run[i]++;
            end else m_run[i] = 0;
            rise = ns && !m_stb[i];
            if (!cfg_en[i]) np[i] = 0;
            else if (cfg_edge[i])
                np[i] = rise ? 1'b1 : ((m_ph == 1 && irq_claim && m_id == i) ? 1'b0 : m_pnd[i]);
            else np[i] = ns && !(will_svc && m_id == i);
            m_stb[i] = ns;
        end
        case (m_ph)
            0: if (m_pnd != 0) begin
                for (int i = N - 1; i >= 0; i--) if (m_pnd[i]) m_id = i;
                m_ph = 1;
            end
            1: if (irq_claim) m_ph = 2;
               else if (!np[m_id]) m_ph = 0;
            default: if (irq_complete) m_ph = 0;
        endcase
        m_pnd = np;
        m_s2  = m_s1;
        m_s1  = irq_in;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("cyc_req",  int'(irq_req), int'(m_ph == 1));
        check("cyc_busy", int'(busy),    int'(m_ph == 2));
        check("cyc_pend", int'(pend),    int'(m_pnd));
        if (m_ph != 0) check("cyc_id", int'(irq_id), m_id);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
            compare_all();
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; cfg_en = '1; cfg_edge = 8'b1111_1101;
        cfg_deb = '0; irq_claim = 1'b0; irq_complete = 1'b0;
        model_reset();
        #23;
        check("rst_req",  int'(irq_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pend", int'(pend), 0);
        check("rst_id",   int'(irq_id), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        step(3);

        // Edge mode, channel 3, no debounce
        irq_in[3] = 1'b1;
        step(3);
        check("e3_pend_edge3", int'(pend[3]), 1);
        check("e3_req_edge3",  int'(irq_req), 0);
        step(1);
        check("e3_req_edge4", int'(irq_req), 1);
        check("e3_id",        int'(irq_id), 3);
        irq_claim = 1'b1; step(1); irq_claim = 1'b0;
        check("e3_busy", int'(busy), 1);
        check("e3_pend_clr", int'(pend[3]), 0);
        step(2);
        irq_complete = 1'b1; step(1); irq_complete = 1'b0;
        check("e3_busy_fall", int'(busy), 0);
        step(5);
        check("e3_no_rereq", int'(irq_req), 0);
        irq_in[3] = 1'b0;
        step(4);

        // Debounce, cfg_deb = 5
        cfg_deb = 8'd5;
        irq_in[0] = 1'b1; step(4); irq_in[0] = 1'b0;
        step(12);
        check("deb_short_pend", int'(pend[0]), 0);
        check("deb_short_req",  int'(irq_req), 0);
        irq_in[0] = 1'b1; step(6); irq_in[0] = 1'b0;
        step(1);
        check("deb_pend_edge7", int'(pend[0]), 0);
        step(1);
        check("deb_pend_edge8", int'(pend[0]), 1);
        step(1);
        check("deb_req", int'(irq_req), 1);
        check("deb_id",  int'(irq_id), 0);
        irq_claim = 1'b1; step(1); irq_claim = 1'b0;
        irq_complete = 1'b1; step(1); irq_complete = 1'b0;
        step(10);
        cfg_deb = 8'd0;

        // Priority 2 over 5
        irq_in[5] = 1'b1; irq_in[2] = 1'b1;
        step(4);
        check("pri_first_id", int'(irq_id), 2);
        irq_claim = 1'b1; step(1); irq_claim = 1'b0;
        irq_complete = 1'b1; step(1); irq_complete = 1'b0;
        check("pri_gap_req", int'(irq_req), 0);
        step(1);
        check("pri_second_req", int'(irq_req), 1);
        check("pri_second_id",  int'(irq_id), 5);
        irq_claim = 1'b1; step(1); irq_claim = 1'b0;
        irq_complete = 1'b1; step(1); irq_complete = 1'b0;
        irq_in[5] = 1'b0; irq_in[2] = 1'b0;
        step(4);

        // Level mode, channel 1
        irq_in[1] = 1'b1;
        step(4);
        check("lvl_id", int'(irq_id), 1);
        irq_claim = 1'b1; step(1); irq_claim = 1'b0;
        check("lvl_pend_svc0", int'(pend[1]), 0);
        step(2);
        check("lvl_pend_svc2", int'(pend[1]), 0);
        irq_complete = 1'b1; step(1); irq_complete = 1'b0;
        check("lvl_gap_req", int'(irq_req), 0);
        step(1);
        check("lvl_rereq", int'(irq_req), 1);
        irq_in[1] = 1'b0;
        step(2);
        check("lvl_hold_req", int'(irq_req), 1);
        step(1);
        check("lvl_drop_req", int'(irq_req), 0);
        check("lvl_drop_busy", int'(busy), 0);
        step(3);

        // Disable during REQ, channel 4
        irq_in[4] = 1'b1;
        step(4);
        check("dis_id", int'(irq_id), 4);
        cfg_en[4] = 1'b0; step(1);
        check("dis_req", int'(irq_req), 0);
        check("dis_pend", int'(pend[4]), 0);
        cfg_en[4] = 1'b1; step(3);
        check("dis_lost_edge", int'(irq_req), 0);
        irq_in[4] = 1'b0; step(4);
        irq_in[4] = 1'b1; step(4);
        check("dis2_req", int'(irq_req), 1);
        cfg_en[4] = 1'b0; irq_claim = 1'b1; step(1);
        cfg_en[4] = 1'b1; irq_claim = 1'b0;
        check("dis2_claim_wins", int'(busy), 1);
        irq_complete = 1'b1; step(1); irq_complete = 1'b0;
        irq_in[4] = 1'b0; step(4);

        // Reset while in service, channel 6
        irq_in[6] = 1'b1;
        step(4);
        irq_claim = 1'b1; step(1); irq_claim = 1'b0;
        check("rs_busy_pre", int'(busy), 1);
        #2 rst_n = 1'b0; irq_in[6] = 1'b0;
        #1;
        model_reset();
        check("rs_busy", int'(busy), 0);
        check("rs_req",  int'(irq_req), 0);
        check("rs_id",   int'(irq_id), 0);
        check("rs_pend", int'(pend), 0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check("rs_no_req", int'(irq_req), 0);
        irq_in[6] = 1'b1;
        step(4);
        check("rs_fresh_req", int'(irq_req), 1);
        check("rs_fresh_id",  int'(irq_id), 6);
        irq_claim = 1'b1; step(1); irq_claim = 1'b0;
        irq_complete = 1'b1; step(1); irq_complete = 1'b0;
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
